// File: rtl/lsu_mem_port.sv
// RV32I load/store port: one req/ack memory transaction per accepted request, with lane
// steering, byte enables, load extension and misalign/illegal checks. Optional LSU_TIMEOUT_EN.
module lsu_mem_port #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misalign,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_WAIT = 2'b01;
  localparam logic [1:0] S_RESP = 2'b10;

  // A zero limit would make the timeout unreachable.
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("lsu_mem_port: TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]  state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [1:0]  lane_q, lane_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_misalign_q, resp_misalign_d;
  logic        resp_err_q, resp_err_d;
`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  logic        acc_illegal;
  logic        acc_misalign;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Request decode: legality, alignment and store lane steering.
  always_comb begin
    acc_illegal  = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                   (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
    acc_misalign = 1'b0;
    st_wdata     = req_wdata;
    st_be        = 4'b1111;
    case (req_funct3[1:0])
      2'b00: begin
        st_wdata = {4{req_wdata[7:0]}};
        st_be    = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        acc_misalign = req_addr[0];
        st_wdata     = {2{req_wdata[15:0]}};
        st_be        = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: acc_misalign = (req_addr[1:0] != 2'b00);
    endcase
    if (!req_we) begin
      st_be = 4'b1111;
    end
  end

  // Load lane extraction and extension from the acked word.
  always_comb begin
    ld_byte = mem_rdata[{lane_q, 3'b000} +: 8];
    ld_half = mem_rdata[{lane_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_be_d        = mem_be_q;
    lane_d          = lane_q;
    funct3_d        = funct3_q;
    resp_valid_d    = 1'b0;
    resp_rdata_d    = resp_rdata_q;
    resp_misalign_d = resp_misalign_q;
    resp_err_d      = resp_err_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d           = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (acc_illegal || acc_misalign) begin
            state_d         = S_RESP;
            resp_valid_d    = 1'b1;
            resp_rdata_d    = 32'd0;
            resp_err_d      = acc_illegal;
            resp_misalign_d = !acc_illegal;
          end else begin
            state_d     = S_WAIT;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wdata_d = st_wdata;
            mem_be_d    = st_be;
            lane_d      = req_addr[1:0];
            funct3_d    = req_funct3;
`ifdef LSU_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          state_d         = S_RESP;
          mem_req_d       = 1'b0;
          mem_we_d        = 1'b0;
          resp_valid_d    = 1'b1;
          resp_rdata_d    = mem_we_q ? 32'd0 : ld_ext;
          resp_err_d      = 1'b0;
          resp_misalign_d = 1'b0;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d         = S_RESP;
          mem_req_d       = 1'b0;
          mem_we_d        = 1'b0;
          resp_valid_d    = 1'b1;
          resp_rdata_d    = 32'd0;
          resp_err_d      = 1'b1;
          resp_misalign_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= 32'd0;
      mem_wdata_q     <= 32'd0;
      mem_be_q        <= 4'b0000;
      lane_q          <= 2'b00;
      funct3_q        <= 3'b000;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= 32'd0;
      resp_misalign_q <= 1'b0;
      resp_err_q      <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q           <= '0;
`endif
    end else begin
      state_q         <= state_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_be_q        <= mem_be_d;
      lane_q          <= lane_d;
      funct3_q        <= funct3_d;
      resp_valid_q    <= resp_valid_d;
      resp_rdata_q    <= resp_rdata_d;
      resp_misalign_q <= resp_misalign_d;
      resp_err_q      <= resp_err_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q           <= cnt_d;
`endif
    end
  end

  // Ready is combinational so a request is never accepted during reset.
  assign req_ready     = (state_q == S_IDLE) && !rst;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_misalign = resp_misalign_q;
  assign resp_err      = resp_err_q;
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_be        = mem_be_q;

endmodule
